// File: rtl/persiana_pkg.sv
// Shared types and helpers for the multi-channel blind controller.
// Contents: mode/state/zone enums, cmd bit positions, target and direction helpers.
package persiana_pkg;

  typedef enum logic [2:0] {NONE, CLOSE, HALF, OPEN, AUTO}          mode_t;
  typedef enum logic [2:0] {IDLE, UP, DOWN, DEAD, FAULT}            state_t;
  // Zones are ordered bottom to top so targets can be compared numerically.
  typedef enum logic [2:0] {UNKNOWN, BOT, LOWER, MID, UPPER, TOP}   zone_t;

  localparam int CMD_W     = 4;
  localparam int CMD_CLOSE = 0;
  localparam int CMD_HALF  = 1;
  localparam int CMD_OPEN  = 2;
  localparam int CMD_AUTO  = 3;

  // Target zone for a mode; UNKNOWN means "no target".
  function automatic zone_t target_of(mode_t m, logic [1:0] lt);
    zone_t z;
    z = UNKNOWN;
    case (m)
      CLOSE:   z = BOT;
      HALF:    z = MID;
      OPEN:    z = TOP;
      AUTO:    z = (lt == 2'b00) ? BOT : (lt == 2'b01) ? MID : TOP;
      default: z = UNKNOWN;
    endcase
    return z;
  endfunction

  // Direction toward target. Without a known position, or when the zone
  // register still names the target but its sensor is off, only a TOP
  // target means "go up"; everything else is approached from above.
  function automatic logic wants_up(zone_t t, zone_t z);
    if (z == UNKNOWN || t == z) return (t == TOP);
    return (t > z);
  endfunction

endpackage

// File: rtl/persiana_channel.sv
// One blind channel: mode capture, zone tracking, motion FSM, optional watchdog.
// Ports: clk, rst_n (async low), i_tick (1-clk advance strobe), i_cmd one-hot
//   {auto,open,half,close}, i_light, i_s_top/i_s_mid/i_s_bot limit sensors,
//   o_up/o_down motor drive, o_fault latched fault.
// Build option: PERSIANA_WATCHDOG_EN adds a TMO_W-bit motion timeout.
module persiana_channel
  import persiana_pkg::*;
#(
  parameter int TMO_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_tick,
  input  logic [CMD_W-1:0] i_cmd,
  input  logic [1:0]       i_light,
  input  logic             i_s_top,
  input  logic             i_s_mid,
  input  logic             i_s_bot,
  output logic             o_up,
  output logic             o_down,
  output logic             o_fault
);

  if (TMO_W < 1) begin : g_bad_tmo
    $error("TMO_W must be at least 1");
  end

  mode_t  r_mode,  w_mode_nx, w_mode_fin;
  zone_t  r_zone,  w_zone_nx, w_tgt;
  state_t r_state, w_state_nx;
  logic   r_up, r_down, r_fault;
  logic   w_conflict, w_hit, w_up_dir, w_wd_sat;

  // Mode: only a clean one-hot command changes it.
  always_comb begin
    w_mode_nx = r_mode;
    if ($onehot(i_cmd)) begin
      if      (i_cmd[CMD_CLOSE]) w_mode_nx = CLOSE;
      else if (i_cmd[CMD_HALF])  w_mode_nx = HALF;
      else if (i_cmd[CMD_OPEN])  w_mode_nx = OPEN;
      else                       w_mode_nx = AUTO;
    end
  end

  // Zone: sensors win; between sensors only the MID exit is resolved.
  always_comb begin
    w_zone_nx = r_zone;
    if      (i_s_bot) w_zone_nx = BOT;
    else if (i_s_top) w_zone_nx = TOP;
    else if (i_s_mid) w_zone_nx = MID;
    else if (r_zone == MID) begin
      if      (r_state == UP)   w_zone_nx = UPPER;
      else if (r_state == DOWN) w_zone_nx = LOWER;
    end
  end

  assign w_tgt      = target_of(w_mode_nx, i_light);
  assign w_up_dir   = wants_up(w_tgt, w_zone_nx);
  assign w_conflict = (i_s_top & i_s_bot) | (i_s_mid & (i_s_top | i_s_bot));
  assign w_hit      = ((w_tgt == BOT) & i_s_bot) | ((w_tgt == MID) & i_s_mid) |
                      ((w_tgt == TOP) & i_s_top);

`ifdef PERSIANA_WATCHDOG_EN
  localparam logic [TMO_W-1:0] WD_LAST = {TMO_W{1'b1}} - 1'b1;
  logic [TMO_W-1:0] r_wd;

  // Fires on the tick that would bring the counter to saturation.
  assign w_wd_sat = ((r_state == UP) || (r_state == DOWN)) && (r_wd == WD_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                 r_wd <= '0;
    else if (i_tick) begin
      if ((r_state == UP) || (r_state == DOWN)) r_wd <= r_wd + 1'b1;
      else                                      r_wd <= '0;
    end
  end
`else
  assign w_wd_sat = 1'b0;
`endif

  always_comb begin
    w_state_nx = r_state;
    w_mode_fin = w_mode_nx;
    case (r_state)
      IDLE:  if (w_tgt != UNKNOWN && !w_hit) w_state_nx = w_up_dir ? UP : DOWN;
      UP:    if (w_hit || i_s_top)           w_state_nx = IDLE;
             else if (!w_up_dir)             w_state_nx = DEAD;
      DOWN:  if (w_hit || i_s_bot)           w_state_nx = IDLE;
             else if (w_up_dir)              w_state_nx = DEAD;
      DEAD:  w_state_nx = IDLE;
      FAULT: if (i_cmd == '0) begin
               w_state_nx = IDLE;
               w_mode_fin = NONE;
             end
      default: w_state_nx = IDLE;
    endcase
    if (w_wd_sat || w_conflict) w_state_nx = FAULT;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode  <= NONE;
      r_zone  <= UNKNOWN;
      r_state <= IDLE;
      r_up    <= 1'b0;
      r_down  <= 1'b0;
      r_fault <= 1'b0;
    end else if (i_tick) begin
      r_mode  <= w_mode_fin;
      r_zone  <= w_zone_nx;
      r_state <= w_state_nx;
      r_up    <= (w_state_nx == UP);
      r_down  <= (w_state_nx == DOWN);
      r_fault <= (w_state_nx == FAULT);
    end
  end

  assign o_up    = r_up;
  assign o_down  = r_down;
  assign o_fault = r_fault;

endmodule

// File: rtl/persiana_multi_ctrl.sv
// NUM_CH-channel automatic blind controller top: shared prescaler plus one
// persiana_channel per blind.
// Ports: clk, rst_n (async low); cmd[4*NUM_CH] one-hot {auto,open,half,close}
//   per channel; light[2*NUM_CH]; s_top/s_mid/s_bot[NUM_CH] sensors;
//   up/down/fault[NUM_CH] outputs; tick_o = prescaler MSB.
// Build option: PERSIANA_WATCHDOG_EN enables the per-channel motion timeout.
module persiana_multi_ctrl
  import persiana_pkg::*;
#(
  parameter int NUM_CH  = 2,
  parameter int PRESC_W = 25,
  parameter int TMO_W   = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [CMD_W*NUM_CH-1:0] cmd,
  input  logic [2*NUM_CH-1:0]     light,
  input  logic [NUM_CH-1:0]       s_top,
  input  logic [NUM_CH-1:0]       s_mid,
  input  logic [NUM_CH-1:0]       s_bot,
  output logic [NUM_CH-1:0]       up,
  output logic [NUM_CH-1:0]       down,
  output logic [NUM_CH-1:0]       fault,
  output logic                    tick_o
);

  logic [PRESC_W-1:0] r_presc;
  logic               w_tick;

  // Tick is the cycle in which the counter wraps back to zero.
  assign w_tick = &r_presc;
  assign tick_o = r_presc[PRESC_W-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_presc <= '0;
    else        r_presc <= r_presc + 1'b1;
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    persiana_channel #(.TMO_W(TMO_W)) u_ch (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_tick  (w_tick),
      .i_cmd   (cmd[CMD_W*g +: CMD_W]),
      .i_light (light[2*g +: 2]),
      .i_s_top (s_top[g]),
      .i_s_mid (s_mid[g]),
      .i_s_bot (s_bot[g]),
      .o_up    (up[g]),
      .o_down  (down[g]),
      .o_fault (fault[g])
    );
  end

endmodule

// File: tb/tb_persiana_multi_ctrl.sv
// Directed bench for persiana_multi_ctrl (NUM_CH=2, PRESC_W=2, TMO_W=3).
// Expected outputs are queued with each stimulus step and popped after the tick.
module tb_persiana_multi_ctrl;
  localparam int NUM_CH = 2;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic [4*NUM_CH-1:0]   cmd = '0;
  logic [2*NUM_CH-1:0]   light = '0;
  logic [NUM_CH-1:0]     s_top = '0, s_mid = '0, s_bot = '0;
  logic [NUM_CH-1:0]     up, down, fault;
  logic                  tick_o;

  int n_cmp = 0, n_err = 0, n_excl = 0;

  typedef struct {
    string      tag;
    logic [1:0] up;
    logic [1:0] down;
    logic [1:0] fault;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  persiana_multi_ctrl #(.NUM_CH(NUM_CH), .PRESC_W(2), .TMO_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .cmd(cmd), .light(light),
    .s_top(s_top), .s_mid(s_mid), .s_bot(s_bot),
    .up(up), .down(down), .fault(fault), .tick_o(tick_o)
  );

  always @(negedge clk) if ((up & down) != '0) n_excl++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Queue the expectation, advance one prescaler tick, then compare.
  task automatic step(input string tag, input logic [1:0] eu, input logic [1:0] ed,
                      input logic [1:0] ef);
    exp_t e;
    sb.push_back('{tag: tag, up: eu, down: ed, fault: ef});
    repeat (4) @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({e.tag, ".up"},    32'(up),    32'(e.up));
    chk({e.tag, ".down"},  32'(down),  32'(e.down));
    chk({e.tag, ".fault"}, 32'(fault), 32'(e.fault));
  endtask

  initial begin
    logic [1:0] eu, ef;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst.up",     32'(up),     0);
    chk("rst.down",   32'(down),   0);
    chk("rst.fault",  32'(fault),  0);
    chk("rst.tick_o", 32'(tick_o), 0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("tick_o.msb", 32'(tick_o), 1);
    repeat (2) @(posedge clk);
    #1;

    // Ch0 OPEN from bottom
    s_bot = 2'b01; cmd[3:0] = 4'b0100;
    step("a_open", 2'b01, 2'b00, 2'b00);
    s_bot[0] = 1'b0;
    step("a_move", 2'b01, 2'b00, 2'b00);
    s_top[0] = 1'b1;
    step("a_top",  2'b00, 2'b00, 2'b00);
    cmd[3:0] = 4'b0101;                 // multi-hot: mode stays OPEN
    step("a_multi", 2'b00, 2'b00, 2'b00);
    cmd[3:0] = 4'b0100;

    // Ch1 HALF from top, stop on MID, then OPEN
    s_top[1] = 1'b1; cmd[7:4] = 4'b0010;
    step("b_half",  2'b00, 2'b10, 2'b00);
    s_top[1] = 1'b0;
    step("b_move",  2'b00, 2'b10, 2'b00);
    s_mid[1] = 1'b1;
    step("b_mid",   2'b00, 2'b00, 2'b00);
    cmd[7:4] = 4'b0100;
    step("b_open",  2'b10, 2'b00, 2'b00);
    s_mid[1] = 1'b0;
    step("b_leave", 2'b10, 2'b00, 2'b00);
    s_top[1] = 1'b1;
    step("b_top",   2'b00, 2'b00, 2'b00);

    // Ch0 AUTO reversal through DEAD
    cmd[3:0] = 4'b1000; light[1:0] = 2'b00;
    step("c_auto", 2'b00, 2'b01, 2'b00);
    s_top[0] = 1'b0;
    step("c_move", 2'b00, 2'b01, 2'b00);
    light[1:0] = 2'b10;
    step("c_dead", 2'b00, 2'b00, 2'b00);
    step("c_idle", 2'b00, 2'b00, 2'b00);
    step("c_up",   2'b01, 2'b00, 2'b00);
    s_top[0] = 1'b1;
    step("c_top",  2'b00, 2'b00, 2'b00);

    // Ch0 sensor conflict while ch1 moves down
    cmd[7:4] = 4'b0001; s_bot[0] = 1'b1;
    step("d_conf",  2'b00, 2'b10, 2'b01);
    s_top[1] = 1'b0;
    step("d_hold",  2'b00, 2'b10, 2'b01);
    s_bot[0] = 1'b0;
    step("d_stay",  2'b00, 2'b10, 2'b01);
    cmd[3:0] = 4'b0000;
    step("d_clear", 2'b00, 2'b10, 2'b00);
    light[1:0] = 2'b00;                 // a stale AUTO would now drive down
    step("d_none",  2'b00, 2'b10, 2'b00);
    s_bot[1] = 1'b1;
    step("d_bot",   2'b00, 2'b00, 2'b00);

    // Ch0 long travel without sensors
    cmd[3:0] = 4'b0001;
    step("e_close", 2'b00, 2'b01, 2'b00);
    s_top[0] = 1'b0; s_bot[0] = 1'b1;
    step("e_bot",   2'b00, 2'b00, 2'b00);
    cmd[3:0] = 4'b0100;
    step("e_up",    2'b01, 2'b00, 2'b00);
    s_bot[0] = 1'b0;
    for (int i = 1; i <= 8; i++) begin
`ifdef PERSIANA_WATCHDOG_EN
      eu = (i < 7) ? 2'b01 : 2'b00;
      ef = (i < 7) ? 2'b00 : 2'b01;
`else
      eu = 2'b01;
      ef = 2'b00;
`endif
      step($sformatf("e_wd%0d", i), eu, 2'b00, ef);
    end

    // Reset mid-motion drops outputs immediately
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("r_async.up",    32'(up),    0);
    chk("r_async.fault", 32'(fault), 0);
    cmd = '0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    chk("r_rel.fault", 32'(fault), 0);
    step("r_idle", 2'b00, 2'b00, 2'b00);
    cmd[3:0] = 4'b0010;                 // HALF from UNKNOWN goes down
    step("r_unk_mid", 2'b00, 2'b01, 2'b00);
    s_mid[0] = 1'b1;
    step("r_mid", 2'b00, 2'b00, 2'b00);

    chk("excl", 32'(n_excl), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
